// File: rtl/fifo_drain_if.sv
// FIFO read port and downstream valid/ready channel of the fifo_drain read controller.
// master is the controller side; slave is the FIFO plus consumer side.
interface fifo_drain_if #(
    parameter int DW = 8
);
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  rd_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_drain.sv
// Read-side controller for a synchronous FIFO with one-cycle read latency. It buffers
// up to two words, presents them over valid/ready and keeps pop/stall statistics.
module fifo_drain #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    fifo_drain_if.master  bus,
    output logic [CW-1:0] pop_cnt,
    output logic [CW-1:0] stall_cnt
);
    logic [1:0]    occ_p0;
    logic          inflight_p0;
    logic [DW-1:0] buf0_p0;
    logic [DW-1:0] buf1_p0;

    logic          m_valid;
    logic          pop;
    logic [2:0]    level;
    logic          wr_hi;

    assign m_valid = (occ_p0 != 2'd0);
    // A flush cycle never counts as an accepted word, even with m_ready high.
    assign pop     = m_valid & bus.m_ready & ~flush;
    assign level   = {1'b0, occ_p0} + {2'b00, inflight_p0} - {2'b00, pop};

    // The returning word lands at slot (occ - pop).
    assign wr_hi   = (occ_p0 == 2'd2) | ((occ_p0 == 2'd1) & ~pop);

    // Combinational path from m_ready keeps a full-rate stream with only two slots.
    assign bus.rd_en   = rst & en & ~flush & ~bus.fifo_empty & (level < 3'd2);
    assign bus.m_valid = m_valid;
    assign bus.m_data  = buf0_p0;

    // Stage p0: capture FIFO read data into the 2-entry buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_p0      <= 2'd0;
            inflight_p0 <= 1'b0;
            buf0_p0     <= '0;
            buf1_p0     <= '0;
            pop_cnt     <= '0;
            stall_cnt   <= '0;
        end else begin
            inflight_p0 <= bus.rd_en;
            if (flush) begin
                occ_p0 <= 2'd0;
            end else begin
                occ_p0 <= level[1:0];
                if (pop)
                    buf0_p0 <= buf1_p0;
                if (inflight_p0) begin
                    if (wr_hi)
                        buf1_p0 <= bus.fifo_dout;
                    else
                        buf0_p0 <= bus.fifo_dout;
                end
            end
            if (pop)
                pop_cnt <= pop_cnt + CW'(1'b1);
            if (m_valid & ~bus.m_ready)
                stall_cnt <= stall_cnt + CW'(1'b1);
        end
    end
endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: queue-based FIFO and buffer reference model, table vectors,
// flush / async reset sequences, randomized traffic, and a CW=4 counter wrap instance.
`timescale 1ns/1ps
module tb_fifo_drain;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, flush;
    logic [15:0] pop_cnt, stall_cnt;
    logic        rst4, en4, flush4;
    logic [3:0]  pop_cnt4, stall_cnt4;

    fifo_drain_if #(.DW(DW)) bus ();
    fifo_drain_if #(.DW(DW)) bus4 ();

    fifo_drain #(.DW(DW), .CW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .bus(bus),
        .pop_cnt(pop_cnt), .stall_cnt(stall_cnt)
    );

    fifo_drain #(.DW(DW), .CW(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .flush(flush4), .bus(bus4),
        .pop_cnt(pop_cnt4), .stall_cnt(stall_cnt4)
    );

    int n_cmp;
    int n_bad;

    // Reference model: FIFO contents, buffered words, word in flight, counters.
    logic [7:0] fifo_q[$];
    logic [7:0] mb[$];
    logic [7:0] got_q[$];
    bit         m_inf;
    logic [7:0] inf_word;
    int         exp_pop, exp_stall, rd_pulses;
    bit         uflow;

    typedef struct {
        int          nwords;
        logic [15:0] rdy;
        int          ncyc;
        int          exp_pop;
        int          exp_stall;
        int          exp_rd;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
        fifo_q.delete(); mb.delete(); got_q.delete();
        bus.fifo_empty = 1'b1; bus.fifo_dout = '0;
        m_inf = 1'b0; inf_word = '0; exp_pop = 0; exp_stall = 0; rd_pulses = 0; uflow = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: entered just after a falling edge with inputs already set.
    task automatic step(input bit push);
        bit mv, rdy, pop, exp_rd, rd_act, fl;
        int lvl;
        #1;
        fl     = flush;
        rdy    = bus.m_ready;
        mv     = (mb.size() != 0);
        pop    = mv && rdy && !fl;
        lvl    = mb.size() + int'(m_inf) - int'(pop);
        exp_rd = rst && en && !fl && (fifo_q.size() != 0) && (lvl < 2);
        chk("m_valid", bus.m_valid, mv);
        if (mv) chk("m_data", bus.m_data, mb[0]);
        chk("rd_en", bus.rd_en, exp_rd);
        chk("pop_cnt", pop_cnt, exp_pop);
        chk("stall_cnt", stall_cnt, exp_stall);
        rd_act = bus.rd_en;
        if (bus.m_valid === 1'b1 && rdy && !fl) got_q.push_back(bus.m_data);
        if (rd_act) rd_pulses++;
        @(posedge clk);
        #1;
        if (fl) begin
            mb.delete();
        end else begin
            if (pop) void'(mb.pop_front());
            if (m_inf) mb.push_back(inf_word);
        end
        m_inf = exp_rd;
        if (pop) exp_pop = (exp_pop + 1) % 65536;
        if (mv && !rdy) exp_stall = (exp_stall + 1) % 65536;
        if (rd_act) begin
            if (fifo_q.size() == 0) uflow = 1'b1;
            else begin
                inf_word = fifo_q.pop_front();
                bus.fifo_dout = inf_word;
            end
        end
        if (push) fifo_q.push_back(8'($urandom_range(0, 255)));
        bus.fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_cmp = 0; n_bad = 0;
        rst = 1'b0; en = 1'b0; flush = 1'b0;
        bus.m_ready = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_dout = '0;
        rst4 = 1'b0; en4 = 1'b1; flush4 = 1'b0;
        bus4.m_ready = 1'b0; bus4.fifo_empty = 1'b1; bus4.fifo_dout = 8'h5A;

        vecs[0] = '{nwords: 3, rdy: 16'hFFFF, ncyc: 6,  exp_pop: 3, exp_stall: 0, exp_rd: 3};
        vecs[1] = '{nwords: 5, rdy: 16'hFFC0, ncyc: 12, exp_pop: 5, exp_stall: 4, exp_rd: 5};
        vecs[2] = '{nwords: 0, rdy: 16'hFFFF, ncyc: 10, exp_pop: 0, exp_stall: 0, exp_rd: 0};
        vecs[3] = '{nwords: 2, rdy: 16'hAAAA, ncyc: 8,  exp_pop: 2, exp_stall: 2, exp_rd: 2};

        // Reset state with a non-empty FIFO and an eager consumer.
        fifo_q.push_back(8'hE1);
        bus.fifo_empty = 1'b0; en = 1'b1; bus.m_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_pop_cnt", pop_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int k = 0; k < vecs[v].nwords; k++) fifo_q.push_back(8'((k + 1) * 17));
            bus.fifo_empty = (fifo_q.size() == 0);
            en = 1'b1;
            for (int c = 0; c < vecs[v].ncyc; c++) begin
                bus.m_ready = vecs[v].rdy[c];
                step(1'b0);
            end
            chk("vec_pop_cnt", pop_cnt, vecs[v].exp_pop);
            chk("vec_stall_cnt", stall_cnt, vecs[v].exp_stall);
            chk("vec_rd_pulses", rd_pulses, vecs[v].exp_rd);
            chk("vec_words", got_q.size(), vecs[v].exp_pop);
            for (int k = 0; k < got_q.size(); k++) chk("vec_order", got_q[k], 8'((k + 1) * 17));
            chk("vec_underflow", uflow, 0);
        end

        // Flush one cycle after the first read: the in-flight word is discarded.
        do_reset();
        for (int k = 0; k < 4; k++) fifo_q.push_back(8'(8'hC1 + k));
        bus.fifo_empty = 1'b0; en = 1'b1; bus.m_ready = 1'b1;
        step(1'b0);
        flush = 1'b1;
        step(1'b0);
        flush = 1'b0;
        #1;
        chk("flush_m_valid", bus.m_valid, 0);
        repeat (8) step(1'b0);
        chk("flush_words", got_q.size(), 3);
        for (int k = 0; k < got_q.size() && k < 3; k++) chk("flush_order", got_q[k], 8'(8'hC2 + k));
        chk("flush_pop_cnt", pop_cnt, 3);
        chk("flush_underflow", uflow, 0);

        // Asynchronous reset between edges while the buffer is full.
        do_reset();
        for (int k = 0; k < 5; k++) fifo_q.push_back(8'(8'h51 + k));
        bus.fifo_empty = 1'b0; en = 1'b1; bus.m_ready = 1'b0;
        repeat (4) step(1'b0);
        chk("pre_arst_stall", stall_cnt, 2);
        chk("pre_arst_valid", bus.m_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_m_valid", bus.m_valid, 0);
        chk("arst_rd_en", bus.rd_en, 0);
        chk("arst_pop_cnt", pop_cnt, 0);
        chk("arst_stall_cnt", stall_cnt, 0);
        mb.delete(); got_q.delete(); m_inf = 1'b0; exp_pop = 0; exp_stall = 0;
        @(negedge clk);
        rst = 1'b1; bus.m_ready = 1'b1;
        repeat (8) step(1'b0);
        chk("arst_words", got_q.size(), 3);
        for (int k = 0; k < got_q.size() && k < 3; k++) chk("arst_order", got_q[k], 8'(8'h53 + k));
        chk("arst_pop_cnt_after", pop_cnt, 3);
        chk("arst_underflow", uflow, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 24) == 0);
            bus.m_ready = ($urandom_range(0, 3) != 0);
            step((fifo_q.size() < 12) && ($urandom_range(0, 1) == 1));
        end
        flush = 1'b0;
        chk("rand_underflow", uflow, 0);

        // Counter wrap on the CW=4 instance: 17 pops leave pop_cnt at 1.
        @(negedge clk);
        rst4 = 1'b1; bus4.fifo_empty = 1'b0; bus4.m_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 17; i++) begin
            #1;
            if (bus4.m_valid === 1'b1) n++;
            @(negedge clk);
        end
        bus4.m_ready = 1'b0; bus4.fifo_empty = 1'b1;
        #1;
        chk("wrap_pops", n, 17);
        chk("wrap_pop_cnt", pop_cnt4, 1);
        chk("wrap_stall_cnt", stall_cnt4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
